// File: rtl/f16div_pkg.sv
// Shared FP16 divide-controller constants, state encoding and flag layout.
// Imported by f16div_ctl and f16div_round.
package f16div_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int MANT_W    = 11;
    localparam int FP16_BIAS = 15;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] INF  = 16'h7C00;

    localparam int DSU_WIDTH = 14;
    localparam int DSU_ITERS = 7;

    // Signed width of the exponent datapath
    localparam int EW = 7;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        WAIT_Q,
        ROUND,
        OUT
    } state_t;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

endpackage

// File: rtl/f16div_round.sv
// Normalize, round-to-nearest-even and pack the f16dsu quotient.
// Flag outputs exist only when F16DIV_CTL_FLAGS_EN is defined.
module f16div_round
    import f16div_pkg::*;
#(
    parameter int DSU_W = DSU_WIDTH
) (
    input  logic [DSU_W-1:0]    q,
    input  logic                sticky,
    input  logic signed [EW-1:0] exp_in,
    input  logic                sign,
`ifdef F16DIV_CTL_FLAGS_EN
    output logic [4:0]          flags,
`endif
    output logic [15:0]         data
);

    logic                 norm;
    logic                 guard;
    logic                 stk;
    logic                 rnd_up;
    logic                 ovf;
    logic                 unf;
    logic [MANT_W-1:0]    sig;
    logic [MANT_W:0]      sum;
    logic [FRAC_W-1:0]    frac;
    logic signed [EW-1:0] e0;
    logic signed [EW-1:0] e1;

    always_comb begin
        norm = q[DSU_W-1] | q[DSU_W-2];
        if (norm) begin
            sig   = q[DSU_W-2 -: MANT_W];
            guard = q[DSU_W-2-MANT_W];
            stk   = sticky | q[0];
            e0    = exp_in;
        end else begin
            sig   = q[DSU_W-3 -: MANT_W];
            guard = q[DSU_W-3-MANT_W];
            stk   = sticky;
            e0    = exp_in - EW'(1);
        end
        rnd_up = guard & (stk | sig[0]);
        sum    = {1'b0, sig} + {{MANT_W{1'b0}}, rnd_up};
        // Carry out of the significand renormalizes to 1.0 at the next exponent
        frac   = sum[MANT_W] ? '0 : sum[FRAC_W-1:0];
        e1     = sum[MANT_W] ? e0 + EW'(1) : e0;
        ovf    = e1 >= EW'(31);
        unf    = e1 <= EW'(0);
        data   = {sign, e1[EXP_W-1:0], frac};
        if (ovf) begin
            data = {sign, INF[14:0]};
        end else if (unf) begin
            data = {sign, 15'd0};
        end
    end

`ifdef F16DIV_CTL_FLAGS_EN
    always_comb begin
        flags          = '0;
        flags[FLAG_OF] = ovf;
        flags[FLAG_UF] = unf;
        flags[FLAG_NX] = ovf | unf | guard | stk;
    end
`endif

endmodule

// File: rtl/f16div_ctl.sv
// FP16 divide controller: issues to f16dsu, collects and rounds the quotient.
// Define F16DIV_CTL_FLAGS_EN to add the out_flags port and flag registers.
module f16div_ctl
    import f16div_pkg::*;
#(
    parameter int EXP_BIAS = FP16_BIAS,
    parameter int DSU_W    = DSU_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_a,
    input  logic [15:0]       in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
`ifdef F16DIV_CTL_FLAGS_EN
    output logic [4:0]        out_flags,
`endif
    output logic              dsu_i_valid,
    output logic              dsu_i_ctrl,
    output logic [DSU_W-1:0]  dsu_i_pr0,
    output logic [MANT_W-1:0] dsu_i_y,
    output logic              dsu_o_ready,
    input  logic              dsu_o_r_done,
    input  logic              dsu_o_q_done,
    input  logic [DSU_W-1:0]  dsu_o_d0,
    input  logic [DSU_W-1:0]  dsu_o_d1
);

    state_t               state;
    state_t               state_nx;
    logic                 sgn_r;
    logic [EXP_W-1:0]     ea_r;
    logic [EXP_W-1:0]     eb_r;
    logic [MANT_W-1:0]    ma_r;
    logic [MANT_W-1:0]    mb_r;
    logic [DSU_W-1:0]     res_r;
    logic [DSU_W-1:0]     q_r;
    logic signed [EW-1:0] e_base;
    logic [15:0]          rnd_data;

    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W-1:0] fa;
    logic [FRAC_W-1:0] fb;
    logic a_nan;
    logic b_nan;
    logic a_snan;
    logic b_snan;
    logic a_inf;
    logic b_inf;
    logic a_zero;
    logic b_zero;
    logic sgn;
    logic special;
    logic [15:0] sp_data;

    assign ea     = in_a[14:10];
    assign eb     = in_b[14:10];
    assign fa     = in_a[9:0];
    assign fb     = in_b[9:0];
    assign sgn    = in_a[15] ^ in_b[15];
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign a_snan = a_nan & ~fa[FRAC_W-1];
    assign b_snan = b_nan & ~fb[FRAC_W-1];
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    // Subnormal inputs are flushed to zero
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    always_comb begin
        special = 1'b1;
        sp_data = QNAN;
        if (a_nan | b_nan) begin
            sp_data = QNAN;
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_data = QNAN;
        end else if (a_inf | b_zero) begin
            sp_data = {sgn, INF[14:0]};
        end else if (b_inf | a_zero) begin
            sp_data = {sgn, 15'd0};
        end else begin
            special = 1'b0;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        dsu_i_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = special ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                dsu_i_valid = 1'b1;
                state_nx    = WAIT_R;
            end
            WAIT_R: if (dsu_o_r_done) state_nx = WAIT_Q;
            WAIT_Q: if (dsu_o_q_done) state_nx = ROUND;
            ROUND:  state_nx = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sgn_r    <= 1'b0;
            ea_r     <= '0;
            eb_r     <= '0;
            ma_r     <= '0;
            mb_r     <= '0;
            res_r    <= '0;
            q_r      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                sgn_r <= sgn;
                ea_r  <= ea;
                eb_r  <= eb;
                ma_r  <= {1'b1, fa};
                mb_r  <= {1'b1, fb};
                if (special) out_data <= sp_data;
            end
            if (state == WAIT_R && dsu_o_r_done) begin
                res_r <= dsu_o_d0 + dsu_o_d1;
            end
            // A negative final residual means q0 overshot; q1 is the true quotient
            if (state == WAIT_Q && dsu_o_q_done) begin
                q_r <= res_r[DSU_W-1] ? dsu_o_d1 : dsu_o_d0;
            end
            if (state == ROUND) out_data <= rnd_data;
        end
    end

    assign e_base = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
                  + EW'(EXP_BIAS);

    assign dsu_i_ctrl  = 1'b0;
    assign dsu_o_ready = 1'b1;
    assign dsu_i_pr0   = {{(DSU_W-MANT_W){1'b0}}, ma_r};
    assign dsu_i_y     = mb_r;

`ifdef F16DIV_CTL_FLAGS_EN
    logic [4:0] sp_flags;
    logic [4:0] rnd_flags;
    logic [4:0] flags_r;

    always_comb begin
        sp_flags          = '0;
        sp_flags[FLAG_NV] = a_snan | b_snan
                          | (~(a_nan | b_nan)
                             & ((a_zero & b_zero) | (a_inf & b_inf)));
        sp_flags[FLAG_DZ] = ~(a_nan | b_nan) & ~a_inf & ~a_zero & b_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= '0;
        end else if (state == IDLE && in_valid && special) begin
            flags_r <= sp_flags;
        end else if (state == ROUND) begin
            flags_r <= rnd_flags;
        end
    end

    assign out_flags = flags_r;
`endif

    f16div_round #(
        .DSU_W (DSU_W)
    ) u_round (
        .q      (q_r),
        .sticky (|res_r),
        .exp_in (e_base),
        .sign   (sgn_r),
`ifdef F16DIV_CTL_FLAGS_EN
        .flags  (rnd_flags),
`endif
        .data   (rnd_data)
    );

endmodule

// File: tb/tb_f16div_ctl.sv
// Randomized self-checking bench for f16div_ctl with an f16dsu stand-in.
// Flag checks are compiled in when F16DIV_CTL_FLAGS_EN is defined.
module tb_f16div_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
`ifdef F16DIV_CTL_FLAGS_EN
    logic [4:0]  out_flags;
`endif
    logic        dsu_i_valid;
    logic        dsu_i_ctrl;
    logic [13:0] dsu_i_pr0;
    logic [10:0] dsu_i_y;
    logic        dsu_o_ready;
    logic        dsu_o_r_done = 1'b0;
    logic        dsu_o_q_done = 1'b0;
    logic [13:0] dsu_o_d0 = '0;
    logic [13:0] dsu_o_d1 = '0;

    int n_chk = 0;
    int n_fail = 0;
    int issues = 0;
    int neg_mode = 0;
    int cnt = 0;
    logic [15:0] cur_a = '0;
    logic [15:0] cur_b = '0;
    logic [13:0] q0r = '0;
    logic [13:0] resr = '0;
    logic [20:0] exp_q[$];

    localparam logic [15:0] DA [9] = '{16'h3C00, 16'h3C00, 16'hBC00,
        16'h4000, 16'h0000, 16'h7BFF, 16'h0400, 16'h7D00, 16'h7C00};
    localparam logic [15:0] DB [9] = '{16'h4000, 16'h4200, 16'h3E00,
        16'h0000, 16'h0000, 16'h3800, 16'h4400, 16'h3C00, 16'h7C00};
    localparam logic [15:0] DD [9] = '{16'h3800, 16'h3555, 16'hB955,
        16'h7C00, 16'h7E00, 16'h7C00, 16'h0000, 16'h7E00, 16'h7E00};
    localparam logic [4:0]  DF [9] = '{5'h00, 5'h01, 5'h01,
        5'h08, 5'h10, 5'h05, 5'h03, 5'h10, 5'h10};
    localparam int          DN [9] = '{0, 2, 1, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    f16div_ctl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
`ifdef F16DIV_CTL_FLAGS_EN
        .out_flags    (out_flags),
`endif
        .dsu_i_valid  (dsu_i_valid),
        .dsu_i_ctrl   (dsu_i_ctrl),
        .dsu_i_pr0    (dsu_i_pr0),
        .dsu_i_y      (dsu_i_y),
        .dsu_o_ready  (dsu_o_ready),
        .dsu_o_r_done (dsu_o_r_done),
        .dsu_o_q_done (dsu_o_q_done),
        .dsu_o_d0     (dsu_o_d0),
        .dsu_o_d1     (dsu_o_d1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact rational quotient rounded to nearest even; returns {flags, data}
    function automatic logic [20:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        int ea, eb, fa, fb, ma, mb, e, num, sig, rem;
        bit s, an, bn, asn, bsn, ai, bi, az, bz;
        s   = a[15] ^ b[15];
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        fa  = int'(a[9:0]);
        fb  = int'(b[9:0]);
        an  = ea == 31 && fa != 0;
        bn  = eb == 31 && fb != 0;
        asn = an && fa < 512;
        bsn = bn && fb < 512;
        ai  = ea == 31 && fa == 0;
        bi  = eb == 31 && fb == 0;
        az  = ea == 0;
        bz  = eb == 0;
        if (an || bn) return {(asn || bsn) ? 5'b10000 : 5'b00000, 16'h7E00};
        if ((az && bz) || (ai && bi)) return {5'b10000, 16'h7E00};
        if (ai) return {5'b00000, s, 15'h7C00};
        if (bz) return {5'b01000, s, 15'h7C00};
        if (bi || az) return {5'b00000, s, 15'h0000};
        ma = 1024 + fa;
        mb = 1024 + fb;
        if (ma >= mb) begin
            e = ea - eb + 15;
            num = ma * 1024;
        end else begin
            e = ea - eb + 14;
            num = ma * 2048;
        end
        sig = num / mb;
        rem = num - sig * mb;
        if (2 * rem > mb || (2 * rem == mb && sig % 2 == 1)) sig++;
        if (sig == 2048) begin
            sig = 1024;
            e++;
        end
        if (e >= 31) return {5'b00101, s, 15'h7C00};
        if (e <= 0) return {5'b00011, s, 15'h0000};
        return {4'b0000, rem != 0, s, 5'(e), 10'(sig - 1024)};
    endfunction

    function automatic bit spec_op(input logic [15:0] a, input logic [15:0] b);
        return a[14:10] == 5'd0 || a[14:10] == 5'd31 ||
               b[14:10] == 5'd0 || b[14:10] == 5'd31;
    endfunction

    function automatic logic [15:0] rnd_fp();
        logic [4:0] e;
        logic [9:0] f;
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) e = 5'd0;
        else if (k == 1) e = 5'd31;
        else if (k < 5) e = 5'($urandom_range(1, 8));
        else if (k < 8) e = 5'($urandom_range(23, 30));
        else e = 5'($urandom_range(1, 30));
        if ($urandom_range(0, 3) == 0) f = 10'(($urandom % 4) << 8);
        else f = 10'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // f16dsu stand-in: r_done 7 cycles after issue, q_done one cycle later
    always @(posedge clk) begin
        int ma, mb, num, qf, r, q0, rs;
        bit neg;
        logic [13:0] d0;
        if (!reset && dsu_i_valid) issues++;
        if (reset) begin
            cnt = 0;
        end else if (cnt == 0) begin
            if (dsu_i_valid) begin
                cnt = 1;
                ma  = 1024 + int'(cur_a[9:0]);
                mb  = 1024 + int'(cur_b[9:0]);
                num = ma * 4096;
                qf  = num / mb;
                r   = num - qf * mb;
                neg = (r != 0) && (neg_mode == 1 ||
                      (neg_mode == 0 && $urandom_range(0, 1) == 1));
                if (neg) begin
                    q0 = qf + 1;
                    rs = r - mb;
                end else begin
                    q0 = qf;
                    rs = r;
                end
                q0r  = 14'(q0);
                resr = 14'(rs);
            end
        end else if (cnt == 9) begin
            cnt = 0;
        end else begin
            cnt++;
        end
        #1;
        if (cnt == 1) begin
            chk("dsu_pr0", dsu_i_pr0, {3'b000, 1'b1, cur_a[9:0]});
            chk("dsu_y", dsu_i_y, {1'b1, cur_b[9:0]});
            chk("dsu_ctrl", dsu_i_ctrl, 0);
        end
        dsu_o_r_done = 1'b0;
        dsu_o_q_done = 1'b0;
        dsu_o_d0 = 14'($urandom);
        dsu_o_d1 = 14'($urandom);
        if (cnt == 7) begin
            d0 = 14'($urandom);
            dsu_o_r_done = 1'b1;
            dsu_o_d0 = d0;
            dsu_o_d1 = resr - d0;
        end else if (cnt == 8) begin
            dsu_o_q_done = 1'b1;
            dsu_o_d0 = q0r;
            dsu_o_d1 = q0r - 14'd1;
            dsu_o_r_done = ($urandom_range(0, 3) == 0);
        end else if (cnt >= 2 && cnt <= 6) begin
            dsu_o_q_done = ($urandom_range(0, 3) == 0);
        end
    end

    // Every cycle the result is presented it must match the scoreboard head
    always @(negedge clk) begin
        logic [20:0] e;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e = exp_q[0];
                chk("out_data", out_data, e[15:0]);
`ifdef F16DIV_CTL_FLAGS_EN
                chk("out_flags", out_flags, e[20:16]);
`endif
                chk("in_ready_in_out", in_ready, 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input int hold, output logic [15:0] d,
                         output logic [4:0] f);
        int n;
        int iss0;
        bit sp;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        sp    = spec_op(a, b);
        cur_a = a;
        cur_b = b;
        exp_q.push_back(model(a, b));
        iss0  = issues;
        in_a  = a;
        in_b  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, sp ? 0 : 10);
        d = out_data;
        f = '0;
`ifdef F16DIV_CTL_FLAGS_EN
        f = out_flags;
`endif
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_data", out_data, d);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("issue_count", issues - iss0, sp ? 0 : 1);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        logic [15:0] d;
        logic [4:0]  f;
        logic [20:0] m;
        logic [15:0] a;
        logic [15:0] b;
        reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dsu_valid", dsu_i_valid, 0);
        chk("rst_dsu_o_ready", dsu_o_ready, 1);
`ifdef F16DIV_CTL_FLAGS_EN
        chk("rst_out_flags", out_flags, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            m = model(DA[i], DB[i]);
            chk("model_pin_data", m[15:0], DD[i]);
            chk("model_pin_flags", m[20:16], DF[i]);
            neg_mode = DN[i];
            do_op(DA[i], DB[i], 0, d, f);
            chk("dir_data", d, DD[i]);
`ifdef F16DIV_CTL_FLAGS_EN
            chk("dir_flags", f, DF[i]);
`endif
        end
        neg_mode = 0;

        do_op(16'h3C00, 16'h4200, 5, d, f);
        chk("hold_result", d, 16'h3555);

        cur_a = 16'h3C00;
        cur_b = 16'h4000;
        in_a = 16'h3C00;
        in_b = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_result", out_valid, 0);
        do_op(16'h3C00, 16'h4000, 0, d, f);
        chk("post_reset", d, 16'h3800);

        for (int i = 0; i < 300; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            do_op(a, b, $urandom_range(0, 3), d, f);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
